// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences PC and instruction fetch through FETCH, DECODE, EXECUTE, UPDATE
// ports: clk, reset (async, active-low); start, ins_address, opcode, ins_ready, exec_done, branch_req in;
//        ins_rd, ir_load, exec_start, pc_inc, pc_load, finish, busy, error, phase, retired out
module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int OP_W = 8,
  parameter logic [OP_W-1:0] NOP_OPCODE = 8'h00,
  parameter logic [ADDR_W-1:0] IRAM_SIZE = 8'd12,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] ins_address,
  input  logic [OP_W-1:0]   opcode,
  input  logic              ins_ready,
  input  logic              exec_done,
  input  logic              branch_req,
  output logic              ins_rd,
  output logic              ir_load,
  output logic              exec_start,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              finish,
  output logic              busy,
  output logic              error,
  output logic [1:0]        phase,
  output logic [15:0]       retired
);
  localparam int TW = ($clog2(FETCH_TIMEOUT + 1) > 4) ? $clog2(FETCH_TIMEOUT + 1) : 4;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, UPDATE, HALT} state_t;
  state_t state, state_nx;
  logic branch_flag;
  logic [TW-1:0] tmo;
  logic timed_out, at_last, is_nop;
  assign timed_out = tmo == TW'(FETCH_TIMEOUT - 1);
  assign at_last = ins_address == IRAM_SIZE - ADDR_W'(1);
  assign is_nop = opcode == NOP_OPCODE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      branch_flag <= 1'b0;
      tmo <= '0;
      retired <= '0;
      error <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE || state == UPDATE) tmo <= '0;
      else if (state == FETCH && !ins_ready) tmo <= tmo + TW'(1);
      if (state == FETCH && !ins_ready && timed_out) error <= 1'b1;
      if (state == EXEC && exec_done) branch_flag <= branch_req;
      if (state == UPDATE && retired != 16'hFFFF) retired <= retired + 16'd1;
    end
  end
  // illegal encodings fall into HALT so a corrupted state can never run the PC
  always_comb begin
    state_nx = HALT;
    case (state)
      IDLE:    state_nx = start ? FETCH : IDLE;
      FETCH:   state_nx = ins_ready ? DECODE : (timed_out ? HALT : FETCH);
      DECODE:  state_nx = is_nop ? HALT : EXEC;
      EXEC:    state_nx = exec_done ? UPDATE : EXEC;
      UPDATE:  state_nx = (!branch_flag && at_last) ? HALT : FETCH;
      default: state_nx = HALT;
    endcase
  end
  assign ins_rd = state == FETCH;
  assign ir_load = ins_rd && ins_ready;
  assign exec_start = state == DECODE && !is_nop;
  assign pc_inc = state == UPDATE && !branch_flag;
  assign pc_load = state == UPDATE && branch_flag;
  assign finish = state == HALT;
  assign busy = state == FETCH || state == DECODE || state == EXEC || state == UPDATE;
  assign phase = (state == DECODE) ? 2'b01 : (state == EXEC) ? 2'b10 : (state == UPDATE) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table plus multi-cycle sequences for fetch_sequencer
module tb_fetch_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, ins_ready = 1'b0, exec_done = 1'b0, branch_req = 1'b0;
  logic [7:0] opcode = 8'h11, pc = 8'd0;
  logic ins_rd, ir_load, exec_start, pc_inc, pc_load, finish, busy, error;
  logic [1:0] phase;
  logic [15:0] retired;
  int tests = 0, fails = 0;
  localparam logic [9:0] E_IDLE = 10'b00_0000000_0;
  localparam logic [9:0] E_F0   = 10'b00_1000001_0;
  localparam logic [9:0] E_F1   = 10'b00_1100001_0;
  localparam logic [9:0] E_DEC  = 10'b01_0010001_0;
  localparam logic [9:0] E_DNOP = 10'b01_0000001_0;
  localparam logic [9:0] E_EX   = 10'b10_0000001_0;
  localparam logic [9:0] E_UP   = 10'b11_0001001_0;
  localparam logic [9:0] E_HLT  = 10'b00_0000010_0;
  typedef struct {
    logic st, rdy, done, br;
    logic [7:0] op;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[17];
  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ins_address(pc), .opcode(opcode),
    .ins_ready(ins_ready), .exec_done(exec_done), .branch_req(branch_req),
    .ins_rd(ins_rd), .ir_load(ir_load), .exec_start(exec_start), .pc_inc(pc_inc),
    .pc_load(pc_load), .finish(finish), .busy(busy), .error(error), .phase(phase),
    .retired(retired)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!reset) pc <= 8'd0;
    else if (pc_load) pc <= 8'd4;
    else if (pc_inc) pc <= pc + 8'd1;
  function automatic logic [9:0] outs();
    return {phase, ins_rd, ir_load, exec_start, pc_inc, pc_load, finish, busy, error};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; ins_ready = 1'b0; exec_done = 1'b0; branch_req = 1'b0; opcode = 8'h11;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  function automatic vec_t mk(input logic st, rdy, done, br, input logic [7:0] op, input logic [9:0] exp);
    vec_t v;
    v.st = st; v.rdy = rdy; v.done = done; v.br = br; v.op = op; v.exp = exp;
    return v;
  endfunction
  initial begin
    int n_inc, n_es, n_rd;
    logic found;
    tbl[0]  = mk(1, 0, 0, 0, 8'h11, E_IDLE);
    tbl[1]  = mk(0, 0, 0, 0, 8'h11, E_F0);
    tbl[2]  = mk(0, 0, 0, 0, 8'h11, E_F0);
    tbl[3]  = mk(0, 0, 0, 0, 8'h11, E_F0);
    tbl[4]  = mk(0, 1, 0, 0, 8'h11, E_F1);
    tbl[5]  = mk(1, 0, 1, 0, 8'h11, E_DEC);
    tbl[6]  = mk(0, 0, 0, 1, 8'h11, E_EX);
    tbl[7]  = mk(0, 0, 0, 0, 8'h11, E_EX);
    tbl[8]  = mk(1, 0, 0, 0, 8'h11, E_EX);
    tbl[9]  = mk(0, 0, 0, 1, 8'h11, E_EX);
    tbl[10] = mk(0, 0, 0, 0, 8'h11, E_EX);
    tbl[11] = mk(0, 0, 1, 0, 8'h11, E_EX);
    tbl[12] = mk(0, 0, 0, 0, 8'h11, E_UP);
    tbl[13] = mk(0, 1, 0, 0, 8'h00, E_F1);
    tbl[14] = mk(0, 0, 0, 0, 8'h00, E_DNOP);
    tbl[15] = mk(1, 0, 0, 0, 8'h00, E_HLT);
    tbl[16] = mk(0, 1, 1, 0, 8'h11, E_HLT);
    #1 chk("reset_outs", 32'(outs()), 32'(E_IDLE));
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start = tbl[i].st; ins_ready = tbl[i].rdy; exec_done = tbl[i].done;
      branch_req = tbl[i].br; opcode = tbl[i].op;
      #1 chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    chk("vec_retired", 32'(retired), 32'd1);
    // back-to-back instructions, then asynchronous reset in EXEC
    do_reset();
    start = 1'b1; ins_ready = 1'b1; exec_done = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1 chk($sformatf("pipe%0d", k), 32'({phase, pc_inc}), 32'({2'(k % 4), 1'(k % 4 == 3)}));
    end
    chk("pipe_retired", 32'(retired), 32'd2);
    @(negedge clk);
    #1 chk("pipe_in_exec", 32'(phase), 32'd2);
    #2 reset = 1'b0;
    #1 chk("async_outs", 32'(outs()), 32'(E_IDLE));
    chk("async_retired", 32'(retired), 32'd0);
    start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    #1 chk("async_idle", 32'(outs()), 32'(E_IDLE));
    // linear program to the end of IRAM
    do_reset();
    start = 1'b1; ins_ready = 1'b1; exec_done = 1'b1; opcode = 8'h11; n_inc = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1 start = 1'b0;
      if (pc_inc) n_inc++;
      if (finish) break;
    end
    chk("lin_incs", 32'(n_inc), 32'd12);
    chk("lin_state", 32'({retired, busy, finish, error}), 32'({16'd12, 3'b010}));
    chk("lin_pc", 32'(pc), 32'd12);
    // NOP at the third instruction
    do_reset();
    start = 1'b1; ins_ready = 1'b1; exec_done = 1'b1; n_inc = 0; n_es = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      opcode = (pc == 8'd2) ? 8'h00 : 8'h22;
      #1 start = 1'b0;
      if (pc_inc) n_inc++;
      if (exec_start) n_es++;
      if (finish) break;
    end
    chk("nop_counts", 32'({8'(n_inc), 8'(n_es)}), 32'({8'd2, 8'd2}));
    chk("nop_state", 32'({retired, finish, busy}), 32'({16'd2, 2'b10}));
    // branch taken at the last address
    do_reset();
    start = 1'b1; ins_ready = 1'b1; exec_done = 1'b1; opcode = 8'h33; found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1 start = 1'b0;
      if (phase == 2'b10 && pc == 8'd11) begin found = 1'b1; break; end
    end
    chk("br_reach", 32'(found), 32'd1);
    branch_req = 1'b1;
    @(negedge clk);
    branch_req = 1'b0;
    #1 chk("br_update", 32'({phase, pc_load, pc_inc}), 32'({2'b11, 2'b10}));
    @(negedge clk);
    #1 chk("br_fetch", 32'({phase, ins_rd, busy, finish, pc}), 32'({2'b00, 3'b110, 8'd4}));
    // fetch timeout
    do_reset();
    start = 1'b1; ins_ready = 1'b0; n_rd = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1 start = 1'b0;
      if (ins_rd) n_rd++;
      if (finish) break;
    end
    chk("to_cycles", 32'(n_rd), 32'd15);
    chk("to_halt", 32'({error, finish, busy}), 32'b110);
    start = 1'b1;
    @(negedge clk);
    #1 chk("to_start_ignored", 32'(outs()), 32'(E_HLT | 10'd1));
    do_reset();
    #1 chk("to_cleared", 32'(outs()), 32'(E_IDLE));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
